// File: rtl/btn_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter among N_BTN push-buttons.
// Latches press ticks, sends BASE_CHAR+index per grant, and guards each transfer with a watchdog.
module btn_tx_scheduler #(
  parameter int unsigned N_BTN     = 4,
  parameter logic [7:0]  BASE_CHAR = 8'h41,
  parameter int unsigned TO_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_tick,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [N_BTN-1:0] pending,
  output logic             busy,
  output logic             drop_tick,
  output logic             timeout_tick
);

  localparam int unsigned    PTR_W     = $clog2(N_BTN);
  localparam logic [TO_W-1:0] TIMER_MAX = '1;
  localparam logic [TO_W-1:0] TIMER_ONE = TO_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant;
  logic [PTR_W-1:0]  rr_pick;
  logic [PTR_W-1:0]  next_ptr;
  logic              pick_found;
  logic [TO_W-1:0]   timer;
  logic [N_BTN-1:0]  clr_mask;
  logic              wait_exit;

  // First pending request at or after rr_ptr, wrapping modulo N_BTN.
  always_comb begin
    rr_pick    = rr_ptr;
    pick_found = 1'b0;
    for (int k = 0; k < int'(N_BTN); k++) begin
      if (!pick_found && pending[(int'(rr_ptr) + k) % int'(N_BTN)]) begin
        pick_found = 1'b1;
        rr_pick    = PTR_W'((int'(rr_ptr) + k) % int'(N_BTN));
      end
    end
  end

  assign next_ptr = (grant == PTR_W'(N_BTN - 1)) ? '0 : grant + PTR_W'(1);

  // The granted request is consumed at the end of START; a same-cycle press re-sets it.
  assign clr_mask = (state == START) ? (N_BTN'(1) << grant) : '0;

  assign drop_tick    = |(btn_tick & pending & ~clr_mask);
  assign timeout_tick = (state == WAIT) && !tx_done_tick && (timer == TIMER_ONE);
  assign wait_exit    = tx_done_tick || (timer == TIMER_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      tx_data  <= '0;
      timer    <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pending  <= (pending & ~clr_mask) | btn_tick;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant    <= rr_pick;
            tx_data  <= BASE_CHAR + 8'(rr_pick);
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          timer <= TIMER_MAX;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer - TIMER_ONE;
          if (wait_exit) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Directed scenarios plus a randomized run against a request-set / round-robin reference model.
module tb_btn_tx_scheduler;

  localparam int unsigned N    = 4;
  localparam logic [7:0]  BASE = 8'h41;
  localparam int unsigned TOW  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_tick;
  logic         tx_done_tick;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [N-1:0] pending;
  logic         busy;
  logic         drop_tick;
  logic         timeout_tick;

  int total = 0;
  int bad   = 0;

  btn_tx_scheduler #(.N_BTN(N), .BASE_CHAR(BASE), .TO_W(TOW)) dut (
    .clk(clk), .reset(reset), .btn_tick(btn_tick), .tx_done_tick(tx_done_tick),
    .tx_start(tx_start), .tx_data(tx_data), .pending(pending), .busy(busy),
    .drop_tick(drop_tick), .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int limit, output bit found, output int n);
    found = 1'b0;
    n = 0;
    for (int i = 0; i < limit && !found; i++) begin
      if (tx_start === 1'b1) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_tick = '0;
    tx_done_tick = 1'b0;
    #3;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    btn_tick = '0;
    tx_done_tick = 1'b0;
    #7;
    v = {tx_start, busy, drop_tick, timeout_tick, pending, tx_data};
    total++;
    if (v !== 16'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0000", v); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    v = {tx_start, busy, drop_tick, timeout_tick, pending, tx_data};
    total++;
    if (v !== 16'h0) begin bad++; $display("FAIL idle_after_reset: got %h want 0000", v); end
  endtask

  task automatic test_single();
    do_reset();
    btn_tick = 4'b0100;
    step();
    btn_tick = '0;
    total++;
    if (pending !== 4'b0100 || tx_start !== 1'b0) begin
      bad++; $display("FAIL single_latch: pending=%b start=%b want 0100/0", pending, tx_start);
    end
    step();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h43 || busy !== 1'b1) begin
      bad++; $display("FAIL single_start: start=%b data=%h busy=%b want 1/43/1", tx_start, tx_data, busy);
    end
    step();
    total++;
    if (tx_start !== 1'b0 || pending !== 4'b0000) begin
      bad++; $display("FAIL single_after_start: start=%b pending=%b want 0/0000", tx_start, pending);
    end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    total++;
    if (busy !== 1'b0 || tx_data !== 8'h43) begin
      bad++; $display("FAIL single_done: busy=%b data=%h want 0/43", busy, tx_data);
    end
  endtask

  task automatic test_multi();
    logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h44};
    bit f;
    int n;
    do_reset();
    btn_tick = 4'b1011;
    step();
    btn_tick = '0;
    for (int k = 0; k < 3; k++) begin
      wait_start(20, f, n);
      total++;
      if (!f || tx_data !== exp_b[k] || (k > 0 && n != 1)) begin
        bad++; $display("FAIL multi_order[%0d]: found=%0d data=%h gap=%0d want 1/%h/1", k, f, tx_data, n, exp_b[k]);
      end
      repeat (10) step();
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
    end
    btn_tick = 4'b1111;
    step();
    btn_tick = '0;
    wait_start(10, f, n);
    total++;
    if (!f || tx_data !== 8'h41) begin
      bad++; $display("FAIL multi_ptr_wrap: found=%0d data=%h want 1/41", f, tx_data);
    end
  endtask

  task automatic test_alternate();
    bit f;
    int n;
    int g;
    logic [7:0] e;
    do_reset();
    btn_tick = 4'b1001;
    step();
    btn_tick = '0;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 0 : 3;
      e = 8'(BASE + g);
      wait_start(20, f, n);
      total++;
      if (!f || tx_data !== e) begin
        bad++; $display("FAIL alternate[%0d]: found=%0d data=%h want 1/%h", k, f, tx_data, e);
      end
      repeat (3) step();
      tx_done_tick = 1'b1;
      btn_tick = N'(1) << g;
      step();
      tx_done_tick = 1'b0;
      btn_tick = '0;
    end
  endtask

  task automatic test_drop();
    bit f;
    int n;
    int extra;
    do_reset();
    btn_tick = 4'b0100;
    step();
    btn_tick = '0;
    wait_start(10, f, n);
    step();
    btn_tick = 4'b0010;
    #1;
    total++;
    if (drop_tick !== 1'b0) begin bad++; $display("FAIL drop_first_tick: got %b want 0", drop_tick); end
    step();
    btn_tick = 4'b0010;
    #1;
    total++;
    if (drop_tick !== 1'b1) begin bad++; $display("FAIL drop_retick: got %b want 1", drop_tick); end
    step();
    btn_tick = '0;
    #1;
    total++;
    if (drop_tick !== 1'b0 || pending !== 4'b0010) begin
      bad++; $display("FAIL drop_one_cycle: drop=%b pending=%b want 0/0010", drop_tick, pending);
    end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    wait_start(5, f, n);
    total++;
    if (!f || tx_data !== 8'h42 || n != 1) begin
      bad++; $display("FAIL drop_serve: found=%0d data=%h gap=%0d want 1/42/1", f, tx_data, n);
    end
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_start === 1'b1) extra++;
      step();
    end
    total++;
    if (extra != 0 || pending !== 4'b0000) begin
      bad++; $display("FAIL drop_single_send: extra_starts=%0d pending=%b want 0/0000", extra, pending);
    end
  endtask

  task automatic test_timeout();
    bit f;
    int n;
    int first_to;
    bit data_ok;
    do_reset();
    btn_tick = 4'b0101;
    step();
    btn_tick = '0;
    wait_start(10, f, n);
    total++;
    if (!f || tx_data !== 8'h41) begin bad++; $display("FAIL to_first: found=%0d data=%h want 1/41", f, tx_data); end
    first_to = 0;
    data_ok = 1'b1;
    for (int k = 1; k <= 20 && first_to == 0; k++) begin
      step();
      if (tx_data !== 8'h41) data_ok = 1'b0;
      if (timeout_tick === 1'b1) first_to = k;
    end
    total++;
    if (first_to != 15 || busy !== 1'b1) begin
      bad++; $display("FAIL to_cycle: got %0d busy=%b want 15/1", first_to, busy);
    end
    total++;
    if (!data_ok) begin bad++; $display("FAIL to_data_stable: got unstable want 41 held"); end
    step();
    total++;
    if (busy !== 1'b0 || timeout_tick !== 1'b0) begin
      bad++; $display("FAIL to_idle: busy=%b to=%b want 0/0", busy, timeout_tick);
    end
    wait_start(5, f, n);
    total++;
    if (!f || tx_data !== 8'h43 || n != 1) begin
      bad++; $display("FAIL to_next: found=%0d data=%h gap=%0d want 1/43/1", f, tx_data, n);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit f;
    int n;
    int starts;
    logic [15:0] v;
    do_reset();
    btn_tick = 4'b0011;
    step();
    btn_tick = '0;
    wait_start(10, f, n);
    step();
    btn_tick = 4'b0001;
    step();
    btn_tick = '0;
    total++;
    if (pending !== 4'b0011 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre: pending=%b busy=%b want 0011/1", pending, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    v = {tx_start, busy, drop_tick, timeout_tick, pending, tx_data};
    total++;
    if (v !== 16'h0) begin bad++; $display("FAIL rst_async: got %h want 0000", v); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_start === 1'b1 || pending !== 4'b0000) starts++;
      step();
    end
    total++;
    if (starts != 0) begin bad++; $display("FAIL rst_no_start: got %0d active cycles want 0", starts); end
  endtask

  task automatic test_start_retick();
    bit f;
    int n;
    do_reset();
    btn_tick = 4'b0100;
    step();
    btn_tick = '0;
    wait_start(10, f, n);
    btn_tick = 4'b0100;
    #1;
    total++;
    if (drop_tick !== 1'b0) begin bad++; $display("FAIL retick_no_drop: got %b want 0", drop_tick); end
    step();
    btn_tick = '0;
    total++;
    if (pending !== 4'b0100) begin bad++; $display("FAIL retick_pending: got %b want 0100", pending); end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    wait_start(5, f, n);
    total++;
    if (!f || tx_data !== 8'h43) begin bad++; $display("FAIL retick_resend: found=%0d data=%h want 1/43", f, tx_data); end
  endtask

  // Model: a set of outstanding requests, a scheduler-free flag and a round-robin pointer.
  task automatic test_random();
    logic [N-1:0] pm;
    logic [N-1:0] tk;
    logic [N-1:0] clr;
    int rr = 0;
    int g = 0;
    int g_next = 0;
    bit free = 1'b1;
    bit in_start = 1'b0;
    bit waiting = 1'b0;
    bit nxt;
    bit dn;
    int wait_left = 0;
    logic [7:0] e;
    do_reset();
    pm = '0;
    for (int c = 0; c < 400; c++) begin
      total++;
      if (tx_start !== in_start || pending !== pm || busy !== !free) begin
        bad++;
        $display("FAIL rand_state c=%0d: start=%b pend=%b busy=%b want %b/%b/%b",
                 c, tx_start, pending, busy, in_start, pm, !free);
      end
      if (in_start) begin
        e = 8'(BASE + g);
        total++;
        if (tx_data !== e) begin bad++; $display("FAIL rand_data c=%0d: got %h want %h", c, tx_data, e); end
      end
      tk = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      dn = 1'b0;
      if (waiting) begin
        if (wait_left == 0) dn = 1'b1;
        else wait_left--;
      end else if ($urandom_range(0, 4) == 0) begin
        dn = 1'b1;
      end
      btn_tick = tk;
      tx_done_tick = dn;
      #1;
      clr = in_start ? (N'(1) << g) : '0;
      total++;
      if (drop_tick !== (|(tk & pm & ~clr)) || timeout_tick !== 1'b0) begin
        bad++;
        $display("FAIL rand_ticks c=%0d: drop=%b to=%b want %b/0", c, drop_tick, timeout_tick, |(tk & pm & ~clr));
      end
      nxt = free && (pm != '0);
      if (nxt) begin
        g_next = -1;
        for (int k = 0; k < int'(N); k++)
          if (g_next < 0 && pm[(rr + k) % int'(N)]) g_next = (rr + k) % int'(N);
      end
      pm = (pm & ~clr) | tk;
      if (waiting && dn) begin
        free = 1'b1;
        waiting = 1'b0;
        rr = (g + 1) % int'(N);
      end
      if (in_start) begin
        waiting = 1'b1;
        wait_left = $urandom_range(0, 7);
      end
      if (nxt) begin
        free = 1'b0;
        g = g_next;
      end
      in_start = nxt;
      step();
    end
    btn_tick = '0;
    tx_done_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    btn_tick = '0;
    tx_done_tick = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_alternate();
    test_drop();
    test_timeout();
    test_reset_mid_wait();
    test_start_retick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
